apb2_rr_arbiter: RTL and testbench

//  Two-requester APB2 master: arbitrates round-robin between two simple req/ack

---
 rtl/apb2_rr_arbiter_pkg.sv | 23 ++
 rtl/rr_grant2.sv | 37 +++
 rtl/apb2_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_apb2_rr_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/apb2_rr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// apb2_arb_pkg: shared types and helpers for the two-port APB2 arbiter. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package apb2_arb_pkg;

  localparam int NREQ = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // LSB of field idx inside a {field1,field0} packed vector
  function automatic int unsigned field_lsb(input int unsigned idx, input int unsigned width);
    return idx * width;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant2.sv
// ---------------------------------------------------------------------------
// rr_grant2: combinational round-robin picker for two requesters. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rr_grant2
  import apb2_arb_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic            last,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_idx
);

  logic [NREQ-1:0] eff;

  always_comb begin
    eff     = req & ~mask;
    gnt     = '0;
    gnt_idx = 1'b0;
    if (eff == 2'b11) begin
      // Tie goes to whoever was not served last
      gnt_idx = ~last;
      gnt     = last ? 2'b01 : 2'b10;
    end else if (eff[0]) begin
      gnt     = 2'b01;
      gnt_idx = 1'b0;
    end else if (eff[1]) begin
      gnt     = 2'b10;
      gnt_idx = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// apb2_rr_arbiter: two-requester round-robin APB2 master with ACCESS timeout. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb2_rr_arbiter
  import apb2_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255,
  parameter int TO_WIDTH   = 8
) (
  input  logic                       pclk,
  input  logic                       presetn,
  input  logic [NREQ-1:0]            req_i,
  input  logic [NREQ-1:0]            write_i,
  input  logic [NREQ-1:0]            prot_i,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NREQ*DATA_WIDTH-1:0] wdata_i,
  output logic [NREQ-1:0]            ack_o,
  output logic                       err_o,
  output logic [DATA_WIDTH-1:0]      rdata_o,
  output logic                       psel_o,
  output logic                       penable_o,
  output logic                       pwrite_o,
  output logic                       pprot_o,
  output logic [ADDR_WIDTH-1:0]      paddr_o,
  output logic [DATA_WIDTH-1:0]      pwdata_o,
  input  logic [DATA_WIDTH-1:0]      prdata_i,
  input  logic                       pready_i,
  input  logic                       pslverr_i
);

  localparam logic [TO_WIDTH-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_WIDTH'(TIMEOUT - 1);

  state_e                state_q, state_d;
  logic [TO_WIDTH-1:0]   cnt_q, cnt_d;
  logic                  gidx_q, gidx_d;
  logic                  last_q, last_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic                  pprot_q, pprot_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [NREQ-1:0]       ack_q, ack_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic [NREQ-1:0]       gnt;
  logic                  gnt_idx;
  logic                  to_hit;

  // The requester just acknowledged is masked so its held req is not regranted
  rr_grant2 u_pick (
    .req     (req_i),
    .mask    (ack_q),
    .last    (last_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign to_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gidx_d    = gidx_q;
    last_d    = last_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pprot_d   = pprot_q;
    paddr_d   = paddr_q;
    pwdata_d  = pwdata_q;
    ack_d     = '0;
    err_d     = 1'b0;
    rdata_d   = '0;
    case (state_q)
      IDLE: begin
        if (|gnt) begin
          gidx_d   = gnt_idx;
          pwrite_d = write_i[gnt_idx];
          pprot_d  = prot_i[gnt_idx];
          paddr_d  = addr_i[field_lsb(32'(gnt_idx), ADDR_WIDTH) +: ADDR_WIDTH];
          pwdata_d = wdata_i[field_lsb(32'(gnt_idx), DATA_WIDTH) +: DATA_WIDTH];
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // pready takes priority over an expiring timeout on the same cycle
        if (pready_i || to_hit) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          ack_d[gidx_q] = 1'b1;
          err_d         = pready_i ? pslverr_i : 1'b1;
          rdata_d       = (pready_i && !pwrite_q) ? prdata_i : '0;
          last_d        = gidx_q;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + TO_WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      gidx_q    <= 1'b0;
      last_q    <= 1'b1;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pprot_q   <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      ack_q     <= '0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gidx_q    <= gidx_d;
      last_q    <= last_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pprot_q   <= pprot_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  assign ack_o     = ack_q;
  assign err_o     = err_q;
  assign rdata_o   = rdata_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign pprot_o   = pprot_q;
  assign paddr_o   = paddr_q;
  assign pwdata_o  = pwdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb2_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_apb2_rr_arbiter: directed plus randomized transaction-level bench. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb2_rr_arbiter;

  localparam int AW = 12;
  localparam int DW = 32;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [1:0]      req_i, write_i, prot_i;
  logic [2*AW-1:0] addr_i;
  logic [2*DW-1:0] wdata_i;
  logic [1:0]      ack_o;
  logic            err_o, psel_o, penable_o, pwrite_o, pprot_o;
  logic [DW-1:0]   rdata_o, pwdata_o, prdata_i;
  logic [AW-1:0]   paddr_o;
  logic            pready_i, pslverr_i;

  apb2_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO), .TO_WIDTH(8)) dut (
    .pclk(clk), .presetn(rst_n), .req_i(req_i), .write_i(write_i), .prot_i(prot_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
    .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o), .pprot_o(pprot_o),
    .paddr_o(paddr_o), .pwdata_o(pwdata_o), .prdata_i(prdata_i), .pready_i(pready_i),
    .pslverr_i(pslverr_i)
  );

  int checks = 0;
  int errors = 0;
  int last_g = 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: a lone request wins, a tie goes to the one not served last
  function automatic int pick(input logic [1:0] r);
    if (r == 2'b11) return 1 - last_g;
    return r[1] ? 1 : 0;
  endfunction

  task automatic set_fields(input int g);
    addr_i[g*AW +: AW]  = AW'($urandom);
    wdata_i[g*DW +: DW] = $urandom;
    write_i[g]          = 1'($urandom_range(0, 1));
    prot_i[g]           = 1'($urandom_range(0, 1));
  endtask

  task automatic idle_check(input string tag);
    @(posedge clk); #1;
    chk(tag, {psel_o, penable_o, ack_o, err_o}, 5'b0);
  endtask

  // Entered just after an edge with requests presented; grant happens on the next edge
  task automatic run_xfer(input int g, input int waits, input logic slverr,
                          input logic [DW-1:0] rd, input bit hold);
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    logic          ewr, epr;
    bit            timed, fin, aborted;
    ea  = addr_i[g*AW +: AW];
    ew  = wdata_i[g*DW +: DW];
    ewr = write_i[g];
    epr = prot_i[g];
    @(posedge clk); #1;
    chk("setup_sel", {psel_o, penable_o}, 2'b10);
    chk("setup_addr", paddr_o, ea);
    chk("setup_wdata", pwdata_o, ew);
    chk("setup_dir_prot", {pwrite_o, pprot_o}, {ewr, epr});
    pready_i = 1'b0;
    @(posedge clk); #1;
    chk("access_en", {psel_o, penable_o, ack_o}, 4'b1100);
    for (int w = 0; w <= TO; w++) begin
      pready_i  = (w == waits);
      prdata_i  = rd;
      pslverr_i = slverr;
      timed     = (w == TO - 1);
      fin       = (w == waits) || timed;
      aborted   = timed && (w != waits);
      @(posedge clk); #1;
      if (fin) begin
        chk("ack", ack_o, 64'(2'b01 << g));
        chk("err", err_o, aborted ? 1'b1 : slverr);
        chk("rdata", rdata_o, (aborted || ewr) ? '0 : rd);
        chk("release", {psel_o, penable_o}, 2'b00);
        chk("hold_addr", {paddr_o, pwdata_o}, {ea, ew});
        break;
      end else begin
        chk("wait_bus", {psel_o, penable_o, ack_o}, 4'b1100);
        chk("wait_stable", {paddr_o, pwdata_o, pwrite_o}, {ea, ew, ewr});
      end
    end
    pready_i  = 1'b1;
    pslverr_i = 1'b0;
    prdata_i  = '0;
    last_g    = g;
    if (!hold) req_i[g] = 1'b0;
  endtask

  initial begin
    logic [1:0] r;
    int g;
    rst_n = 1'b0; req_i = '0; write_i = '0; prot_i = '0; addr_i = '0; wdata_i = '0;
    prdata_i = '0; pready_i = 1'b1; pslverr_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", {psel_o, penable_o, pwrite_o, pprot_o, ack_o, err_o}, 7'b0);
    chk("reset_data", {paddr_o, pwdata_o, rdata_o}, '0);
    rst_n = 1'b1;
    idle_check("idle_after_reset");

    // Single read from requester 0
    addr_i[0 +: AW] = 12'h010; wdata_i[0 +: DW] = 32'h1234_5678; write_i[0] = 1'b0; prot_i[0] = 1'b0;
    req_i = 2'b01;
    run_xfer(0, 0, 1'b0, 32'hCAFE_0001, 1'b0);
    @(posedge clk); #1;
    chk("resp_cleared", {ack_o, err_o, rdata_o}, '0);

    // Continuous contention alternates grants with one IDLE cycle between
    set_fields(0); set_fields(1);
    req_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = pick(2'b11);
      run_xfer(g, $urandom_range(0, 2), 1'b0, $urandom, 1'b1);
    end
    req_i = 2'b00;
    idle_check("idle_after_contention");

    // Write with three wait states ending in a slave error
    set_fields(1); write_i[1] = 1'b1;
    req_i = 2'b10;
    run_xfer(1, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);
    idle_check("idle_after_wait");

    // Hung slave forces a timeout abort, then a normal transfer follows
    set_fields(0); write_i[0] = 1'b0;
    req_i = 2'b01;
    run_xfer(0, 9, 1'b0, 32'h5555_AAAA, 1'b0);
    idle_check("idle_after_timeout");
    set_fields(0);
    req_i = 2'b01;
    run_xfer(0, 1, 1'b0, 32'h0BAD_F00D, 1'b0);
    idle_check("idle_after_recovery");

    // pready arrives exactly on the timeout cycle
    set_fields(1); write_i[1] = 1'b0;
    req_i = 2'b10;
    run_xfer(1, TO - 1, 1'b0, 32'h7777_0006, 1'b0);
    idle_check("idle_after_tie");

    // Randomized traffic against the round-robin rules
    for (int it = 0; it < 30; it++) begin
      if (req_i == 2'b00) begin
        r = 2'($urandom_range(1, 3));
        if (r[0]) set_fields(0);
        if (r[1]) set_fields(1);
        req_i = r;
      end
      g = pick(req_i);
      run_xfer(g, $urandom_range(0, 5), 1'($urandom_range(0, 1)), $urandom, 1'b0);
      if (req_i == 2'b00) idle_check("rand_idle");
    end

    // Asynchronous reset during ACCESS releases the bus without an ack
    set_fields(0);
    req_i = 2'b01;
    pready_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_access", {psel_o, penable_o}, 2'b11);
    rst_n = 1'b0;
    #1;
    chk("async_reset_ctl", {psel_o, penable_o, pwrite_o, pprot_o, ack_o, err_o}, 7'b0);
    chk("async_reset_data", {paddr_o, pwdata_o, rdata_o}, '0);
    @(posedge clk); #1;
    chk("reset_no_ack", ack_o, 2'b00);
    pready_i = 1'b1;
    last_g = 1;
    set_fields(0); set_fields(1);
    req_i = 2'b11;
    rst_n = 1'b1;
    run_xfer(pick(2'b11), 0, 1'b0, 32'hA0A0_0000, 1'b0);
    run_xfer(pick(req_i), 1, 1'b0, 32'hB1B1_0001, 1'b0);
    idle_check("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
